// File: rtl/prbs_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prbs_pkg
// Brief   : Shared constants, FSM state type and LFSR helpers for the PRBS15
//           burst sequencer.
// Revision: 1.0
// ============================================================================
package prbs_pkg;

  localparam int             PRBS15_W        = 15;
  // Feedback taps at bit positions 14 and 13, which implements g(x)=1+x^14+x^15.
  localparam logic [14:0]    PRBS15_TAPS     = 15'h6000;
  localparam logic [14:0]    PRBS15_SEED_DEF = 15'h0001;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } state_t;

  function automatic logic [PRBS15_W-1:0] prbs15_next(input logic [PRBS15_W-1:0] s);
    return {s[PRBS15_W-2:0], ^(s & PRBS15_TAPS)};
  endfunction

  // An all-zero seed would lock the LFSR up, so it is replaced by the default.
  function automatic logic [PRBS15_W-1:0] prbs15_fix_seed(input logic [PRBS15_W-1:0] s);
    return (s == '0) ? PRBS15_SEED_DEF : s;
  endfunction

endpackage
`default_nettype wire

// File: rtl/prbs_burst_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : prbs_burst_ctrl_if
// Brief   : Command and serial-output handshake bundle for prbs_burst_ctrl.
// Revision: 1.0
// ============================================================================
interface prbs_burst_ctrl_if #(
  parameter int LEN_W = 16
);

  logic                          cmd_valid;
  logic                          cmd_ready;
  logic [prbs_pkg::PRBS15_W-1:0] cmd_seed;
  logic [LEN_W-1:0]              cmd_len;
  logic                          out_valid;
  logic                          out_ready;
  logic                          out_bit;

  modport master (
    output cmd_valid, cmd_seed, cmd_len, out_ready,
    input  cmd_ready, out_valid, out_bit
  );

  modport slave (
    input  cmd_valid, cmd_seed, cmd_len, out_ready,
    output cmd_ready, out_valid, out_bit
  );

endinterface
`default_nettype wire

// File: rtl/prbs15_lfsr.sv
`default_nettype none
// ============================================================================
// Module  : prbs15_lfsr
// Brief   : Loadable 15-bit Fibonacci LFSR; serial output is the MSB.
// Revision: 1.0
// ============================================================================
module prbs15_lfsr
  import prbs_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic                load_i,
  input  logic [PRBS15_W-1:0] seed_i,
  input  logic                step_i,
  output logic                bit_o
);

  logic [PRBS15_W-1:0] state_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= PRBS15_SEED_DEF;
    end else if (load_i) begin
      state_q <= seed_i;
    end else if (step_i) begin
      state_q <= prbs15_next(state_q);
    end
  end

  assign bit_o = state_q[PRBS15_W-1];

endmodule
`default_nettype wire

// File: rtl/prbs_burst_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : prbs_burst_ctrl
// Brief   : Command-driven PRBS15 burst sequencer with backpressure and abort.
// Revision: 1.0
// ============================================================================
module prbs_burst_ctrl
  import prbs_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  prbs_burst_ctrl_if.slave  bus_io,
  input  logic              abort_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              aborted_o,
  output logic [LEN_W-1:0]  remaining_o
);

  state_t              state_q;
  logic [PRBS15_W-1:0] seed_q;
  logic [LEN_W-1:0]    remaining_q;
  logic                cmd_ready_q;
  logic                out_valid_q;
  logic                busy_q;
  logic                done_q;
  logic                aborted_q;

  logic                hs;
  logic                last;
  logic                lfsr_bit;

  // out_valid_q is high exactly while in RUN, so it doubles as the RUN qualifier.
  assign hs   = out_valid_q && bus_io.out_ready;
  assign last = (remaining_q == LEN_W'(1));

  prbs15_lfsr u_lfsr (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (state_q == LOAD),
    .seed_i (seed_q),
    .step_i (hs),
    .bit_o  (lfsr_bit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      seed_q      <= PRBS15_SEED_DEF;
      remaining_q <= '0;
      cmd_ready_q <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      aborted_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (bus_io.cmd_valid) begin
            seed_q      <= prbs15_fix_seed(bus_io.cmd_seed);
            remaining_q <= bus_io.cmd_len;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            aborted_q   <= 1'b0;
            state_q     <= LOAD;
          end
        end
        LOAD: begin
          if (abort_i) begin
            remaining_q <= '0;
            aborted_q   <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (remaining_q == '0) begin
            done_q  <= 1'b1;
            state_q <= DONE;
          end else begin
            out_valid_q <= 1'b1;
            state_q     <= RUN;
          end
        end
        RUN: begin
          // A final handshake wins over a simultaneous abort: the burst completes normally.
          if (hs && last) begin
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (abort_i) begin
            remaining_q <= '0;
            out_valid_q <= 1'b0;
            aborted_q   <= 1'b1;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else if (hs) begin
            remaining_q <= remaining_q - LEN_W'(1);
          end
        end
        DONE: begin
          busy_q      <= 1'b0;
          cmd_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus_io.cmd_ready = cmd_ready_q;
  assign bus_io.out_valid = out_valid_q;
  assign bus_io.out_bit   = out_valid_q & lfsr_bit;

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign aborted_o   = aborted_q;
  assign remaining_o = remaining_q;

endmodule
`default_nettype wire
